collision_event_manager: RTL and testbench

//  Downstream of the game controller. Takes its per-pixel collision levels (wallCollision,

---
 rtl/game_pkg.sv | 15 +
 rtl/bcd_saturating_adder.sv | 35 +++
 rtl/collision_event_manager.sv | 153 +++++++++++++++
 tb/tb_collision_event_manager.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the score FSM state type.
package game_pkg;

    localparam int NUM_FRUITS   = 5;
    localparam int SCORE_DIGITS = 4;

    // BCD increment awarded for each newly eaten fruit.
    localparam logic [SCORE_DIGITS*4-1:0] FRUIT_POINTS = 16'h0050;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } score_state_t;

endpackage

// File: rtl/bcd_saturating_adder.sv
// Combinational multi-digit BCD adder. It propagates the carry digit by digit.
// A carry out of the top digit clamps the result to all nines.
module bcd_saturating_adder #(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS*4-1:0] a,
    input  logic [DIGITS*4-1:0] b,
    output logic [DIGITS*4-1:0] sum
);

    logic [DIGITS*4-1:0] raw;
    logic                carry;
    logic [4:0]          digit_sum;

    // Ripple the decimal carry through each digit, then clamp on overflow.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the block leaves one unassigned and no latch can be inferred.
        raw       = '0;
        carry     = 1'b0;
        digit_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, carry};
            if (digit_sum > 5'd9) begin
                raw[i*4 +: 4] = 4'(digit_sum - 5'd10);
                carry         = 1'b1;
            end else begin
                raw[i*4 +: 4] = digit_sum[3:0];
                carry         = 1'b0;
            end
        end
        sum = carry ? {DIGITS{4'h9}} : raw;
    end

endmodule

// File: rtl/collision_event_manager.sv
// Collision event manager. It takes the per-pixel collision levels and reduces them
// to one decision per video frame. Outputs are one-shot wall and fruit events, a
// rope level, a sticky fruit-gone mask, a level-cleared pulse and a saturating BCD
// score. A small FSM adds the points for each eaten fruit, one fruit per cycle.
module collision_event_manager #(
    parameter int                          NUM_FRUITS   = game_pkg::NUM_FRUITS,
    parameter int                          SCORE_DIGITS = game_pkg::SCORE_DIGITS,
    parameter logic [SCORE_DIGITS*4-1:0]   FRUIT_POINTS = game_pkg::FRUIT_POINTS
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      restart,
    input  logic                      wallCollision,
    input  logic                      ropeCollision,
    input  logic [NUM_FRUITS-1:0]     fruitCollision,
    output logic                      wallHit,
    output logic                      onRope,
    output logic [NUM_FRUITS-1:0]     fruitEaten,
    output logic [NUM_FRUITS-1:0]     fruitGone,
    output logic [SCORE_DIGITS*4-1:0] score,
    output logic                      levelCleared,
    output logic                      busy
);

    import game_pkg::*;

    localparam logic [NUM_FRUITS-1:0] ALL_GONE = '1;

    // Collisions gathered since the last committed frame boundary.
    logic                  pend_wall;
    logic                  pend_rope;
    logic [NUM_FRUITS-1:0] pend_fruit;

    // Wall contact of the last committed frame, used to detect new contact.
    logic                  prev_wall;

    // Fruits committed but not yet added to the score.
    logic [NUM_FRUITS-1:0] add_mask;
    logic [NUM_FRUITS-1:0] add_lowest;

    score_state_t              state;
    score_state_t              state_next;
    logic                      add_en;
    logic                      commit;
    logic [NUM_FRUITS-1:0]     gone_next;
    logic [SCORE_DIGITS*4-1:0] score_sum;

    // A frame boundary is only honoured while the scorer is idle. Restart takes
    // precedence, so a boundary that coincides with a restart is dropped.
    assign commit     = startOfFrame && (state == IDLE) && !restart;
    assign gone_next  = fruitGone | pend_fruit;
    assign add_lowest = add_mask & (~add_mask + NUM_FRUITS'(1));

    bcd_saturating_adder #(
        .DIGITS (SCORE_DIGITS)
    ) u_score_adder (
        .a   (score),
        .b   (FRUIT_POINTS),
        .sum (score_sum)
    );

    // Score FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: registers use non-blocking assignments, so every flop samples the
        // values from before the clock edge, whatever order the statements are in.
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Score FSM next state: go to ADD once a commit carries eaten fruits, and
    // return to IDLE after the add that consumes the last remaining fruit.
    always_comb begin
        state_next = state;
        add_en     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (commit && (pend_fruit != '0)) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                busy   = 1'b1;
                add_en = !restart;
                if (restart || ((add_mask & ~add_lowest) == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulate per-pixel collisions. On a frame boundary, commit them to the
    // event outputs. On a restart, clear all fruit state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_wall    <= 1'b0;
            pend_rope    <= 1'b0;
            pend_fruit   <= '0;
            prev_wall    <= 1'b0;
            add_mask     <= '0;
            wallHit      <= 1'b0;
            onRope       <= 1'b0;
            fruitEaten   <= '0;
            fruitGone    <= '0;
            levelCleared <= 1'b0;
        end else begin
            wallHit      <= 1'b0;
            fruitEaten   <= '0;
            levelCleared <= 1'b0;
            if (restart) begin
                fruitGone  <= '0;
                pend_fruit <= '0;
                add_mask   <= '0;
                pend_wall  <= pend_wall | wallCollision;
                pend_rope  <= pend_rope | ropeCollision;
            end else if (commit) begin
                onRope       <= pend_rope;
                wallHit      <= pend_wall & ~prev_wall;
                prev_wall    <= pend_wall;
                fruitEaten   <= pend_fruit;
                fruitGone    <= gone_next;
                add_mask     <= pend_fruit;
                levelCleared <= (gone_next == ALL_GONE) && (fruitGone != ALL_GONE);
                // Collisions seen in the boundary cycle belong to the new frame.
                pend_wall    <= wallCollision;
                pend_rope    <= ropeCollision;
                pend_fruit   <= fruitCollision & ~gone_next;
            end else begin
                pend_wall  <= pend_wall | wallCollision;
                pend_rope  <= pend_rope | ropeCollision;
                pend_fruit <= pend_fruit | (fruitCollision & ~fruitGone);
                if (add_en) begin
                    add_mask <= add_mask & ~add_lowest;
                end
            end
        end
    end

    // Score register: one fruit's worth of points per ADD cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score <= '0;
        end else if (add_en) begin
            score <= score_sum;
        end
    end

endmodule

// File: tb/tb_collision_event_manager.sv
// Self-checking bench for collision_event_manager. A frame-level model predicts
// each commit's effects and pushes them to a scoreboard. The effects are popped and
// compared once the DUT shows the committed frame.
module tb_collision_event_manager;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        restart;
    logic        wallCollision;
    logic        ropeCollision;
    logic [4:0]  fruitCollision;
    logic        wallHit;
    logic        onRope;
    logic [4:0]  fruitEaten;
    logic [4:0]  fruitGone;
    logic [15:0] score;
    logic        levelCleared;
    logic        busy;

    collision_event_manager dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .restart        (restart),
        .wallCollision  (wallCollision),
        .ropeCollision  (ropeCollision),
        .fruitCollision (fruitCollision),
        .wallHit        (wallHit),
        .onRope         (onRope),
        .fruitEaten     (fruitEaten),
        .fruitGone      (fruitGone),
        .score          (score),
        .levelCleared   (levelCleared),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  eaten;
        logic [4:0]  gone;
        logic        wall_hit;
        logic        on_rope;
        logic        level_cleared;
        int          k;
        logic [15:0] score;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state.
    logic [4:0] m_gone;
    logic [4:0] m_pend_fruit;
    logic       m_pend_wall;
    logic       m_pend_rope;
    logic       m_prev_wall;
    logic       m_on_rope;
    int         m_score;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_gone       = '0;
        m_pend_fruit = '0;
        m_pend_wall  = 1'b0;
        m_pend_rope  = 1'b0;
        m_prev_wall  = 1'b0;
        m_on_rope    = 1'b0;
        m_score      = 0;
    endtask

    // Drive px collision cycles followed by one startOfFrame cycle, which carries
    // its own collision inputs. Returns at the negedge of cycle T+1.
    task automatic drive_frame(input logic [4:0] f, input logic w, input logic r, input int px,
                               input logic [4:0] sf, input logic sw, input logic sr);
        exp_t e;
        for (int i = 0; i < px; i++) begin
            fruitCollision = f;
            wallCollision  = w;
            ropeCollision  = r;
            m_pend_fruit   = m_pend_fruit | (f & ~m_gone);
            m_pend_wall    = m_pend_wall | w;
            m_pend_rope    = m_pend_rope | r;
            @(negedge clk);
        end
        startOfFrame   = 1'b1;
        fruitCollision = sf;
        wallCollision  = sw;
        ropeCollision  = sr;
        e.eaten         = m_pend_fruit;
        e.wall_hit      = m_pend_wall & ~m_prev_wall;
        e.on_rope       = m_pend_rope;
        e.gone          = m_gone | m_pend_fruit;
        e.level_cleared = (e.gone == 5'h1f) && (m_gone != 5'h1f);
        e.k             = $countones(m_pend_fruit);
        m_score         = m_score + 50 * e.k;
        if (m_score > 9999) m_score = 9999;
        e.score         = to_bcd(m_score);
        m_prev_wall     = m_pend_wall;
        m_on_rope       = m_pend_rope;
        m_gone          = e.gone;
        m_pend_fruit    = sf & ~m_gone;
        m_pend_wall     = sw;
        m_pend_rope     = sr;
        sb_q.push_back(e);
        @(negedge clk);
        startOfFrame   = 1'b0;
        fruitCollision = '0;
        wallCollision  = 1'b0;
        ropeCollision  = 1'b0;
    endtask

    // Called at the negedge of T+1. It checks the commit, checks that the pulses end
    // at T+2, and checks the busy length and the final score.
    task automatic observe(input string tag);
        exp_t e;
        int   busy_n;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".eaten"},    fruitEaten,   e.eaten);
        check({tag, ".gone"},     fruitGone,    e.gone);
        check({tag, ".wall_hit"}, wallHit,      e.wall_hit);
        check({tag, ".on_rope"},  onRope,       e.on_rope);
        check({tag, ".lvl_clr"},  levelCleared, e.level_cleared);
        busy_n = (busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        check({tag, ".eaten_end"},   fruitEaten,   5'b0);
        check({tag, ".wall_end"},    wallHit,      1'b0);
        check({tag, ".lvl_clr_end"}, levelCleared, 1'b0);
        check({tag, ".rope_hold"},   onRope,       e.on_rope);
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin
            busy_n++;
            @(negedge clk);
        end
        check({tag, ".busy_cycles"}, busy_n, e.k);
        check({tag, ".score"},       score,  e.score);
    endtask

    task automatic do_restart(input logic with_sof, input string tag);
        restart      = 1'b1;
        startOfFrame = with_sof;
        m_gone       = '0;
        m_pend_fruit = '0;
        @(negedge clk);
        restart      = 1'b0;
        startOfFrame = 1'b0;
        check({tag, ".gone"},    fruitGone, 5'b0);
        check({tag, ".eaten"},   fruitEaten, 5'b0);
        check({tag, ".busy"},    busy, 1'b0);
        check({tag, ".score"},   score, to_bcd(m_score));
        check({tag, ".on_rope"}, onRope, m_on_rope);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        resetN         = 1'b0;
        startOfFrame   = 1'b0;
        restart        = 1'b0;
        wallCollision  = 1'b0;
        ropeCollision  = 1'b0;
        fruitCollision = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst.score", score, 16'h0000);
        check("rst.gone",  fruitGone, 5'b0);
        check("rst.busy",  busy, 1'b0);
        check("rst.rope",  onRope, 1'b0);
        resetN = 1'b1;
        @(negedge clk);

        // Single fruit, long contact.
        drive_frame(5'b00100, 1'b0, 1'b0, 40, 5'b0, 1'b0, 1'b0);
        observe("t1");
        check("t1.score_abs", score, 16'h0050);

        // Three fruits in one frame.
        drive_frame(5'b10011, 1'b0, 1'b0, 6, 5'b0, 1'b0, 1'b0);
        observe("t2");
        check("t2.score_abs", score, 16'h0200);

        // Already eaten fruit touched again.
        drive_frame(5'b00100, 1'b0, 1'b0, 10, 5'b0, 1'b0, 1'b0);
        observe("t3");

        // Wall in N, N+1, none in N+2, wall in N+3; rope varies.
        drive_frame(5'b0, 1'b1, 1'b1, 5, 5'b0, 1'b0, 1'b0);
        observe("t4n0");
        check("t4n0.hit_abs", 32'(sb_q.size()), 32'd0);
        drive_frame(5'b0, 1'b1, 1'b0, 5, 5'b0, 1'b0, 1'b0);
        observe("t4n1");
        drive_frame(5'b0, 1'b0, 1'b1, 5, 5'b0, 1'b0, 1'b0);
        observe("t4n2");
        drive_frame(5'b0, 1'b1, 1'b0, 5, 5'b0, 1'b0, 1'b0);
        observe("t4n3");

        // Collisions in the boundary cycle count toward the following frame.
        drive_frame(5'b0, 1'b0, 1'b0, 3, 5'b0, 1'b0, 1'b0);
        observe("t6pre");
        drive_frame(5'b0, 1'b0, 1'b0, 3, 5'b01000, 1'b1, 1'b0);
        observe("t6a");
        drive_frame(5'b0, 1'b0, 1'b0, 3, 5'b0, 1'b0, 1'b0);
        observe("t6b_lvl");

        // Restart keeps the score. Restart together with a boundary drops the commit.
        do_restart(1'b0, "t5rst");
        for (int i = 0; i < 3; i++) begin
            fruitCollision = 5'b00010;
            m_pend_fruit   = m_pend_fruit | 5'b00010;
            @(negedge clk);
        end
        fruitCollision = '0;
        do_restart(1'b1, "t5rst_sof");
        drive_frame(5'b0, 1'b0, 1'b0, 2, 5'b0, 1'b0, 1'b0);
        observe("t5after");

        // Climb toward the top of the score range, one full level at a time.
        for (int lvl = 0; lvl < 38; lvl++) begin
            drive_frame(5'h1f, 1'b0, 1'b0, 2, 5'b0, 1'b0, 1'b0);
            observe($sformatf("lvl%0d", lvl));
            do_restart(1'b0, $sformatf("lvl%0d_rst", lvl));
        end
        drive_frame(5'b01111, 1'b0, 1'b0, 2, 5'b0, 1'b0, 1'b0);
        observe("sat_pre");
        check("sat_pre.score_abs", score, 16'h9950);
        drive_frame(5'b10000, 1'b0, 1'b0, 2, 5'b0, 1'b0, 1'b0);
        observe("sat");
        check("sat.score_abs", score, 16'h9999);
        do_restart(1'b0, "sat_rst");
        drive_frame(5'b00001, 1'b0, 1'b0, 2, 5'b0, 1'b0, 1'b0);
        observe("sat_hold");
        check("sat_hold.score_abs", score, 16'h9999);

        // Reset asserted while the scorer is mid-ADD.
        do_restart(1'b0, "r_pre");
        drive_frame(5'b00111, 1'b0, 1'b1, 4, 5'b0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        check("rmid.busy_before",  busy, 1'b1);
        check("rmid.eaten_before", fruitEaten, e.eaten);
        resetN = 1'b0;
        #1;
        check("rmid.busy",   busy, 1'b0);
        check("rmid.score",  score, 16'h0000);
        check("rmid.gone",   fruitGone, 5'b0);
        check("rmid.eaten",  fruitEaten, 5'b0);
        check("rmid.rope",   onRope, 1'b0);
        check("rmid.wall",   wallHit, 1'b0);
        check("rmid.lvlclr", levelCleared, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        @(negedge clk);
        drive_frame(5'b00001, 1'b0, 1'b0, 3, 5'b0, 1'b0, 1'b0);
        observe("post_rst");
        check("post_rst.score_abs", score, 16'h0050);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
